// File: rtl/qam_frame_buffer_ctrl_if.sv
// Symbol/host bundle for qam_frame_buffer_ctrl.
// master: demapper/host side that drives symbols and read requests.
// slave: the frame buffer controller.
interface qam_frame_buffer_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 7
);
    logic             sym_valid;
    logic [WIDTH-1:0] sym_data;
    logic             read_enable;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             available;
    logic             complete;
    logic             frame_done;
    logic [CNT_W-1:0] fill_level;
    logic [1:0]       state;
    logic [15:0]      drop_count;

    modport master (
        output sym_valid, sym_data, read_enable,
        input  rd_valid, rd_data, available, complete, frame_done,
               fill_level, state, drop_count
    );

    modport slave (
        input  sym_valid, sym_data, read_enable,
        output rd_valid, rd_data, available, complete, frame_done,
               fill_level, state, drop_count
    );
endinterface

// File: rtl/qam_frame_buffer_ctrl.sv
// QAM frame buffer controller: buffers demapped symbols in a FIFO, groups
// them into frames of FRAME_LEN symbols and streams each frame to the host
// under read_enable flow control.
// Optional feature: define QAM_DROP_COUNT_EN to build the saturating
// dropped-symbol counter; otherwise drop_count is tied to zero.
module qam_frame_buffer_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input logic                    dclk,
    input logic                    reset,
    input logic                    enable,
    qam_frame_buffer_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FRAME_LVL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_POP  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        READY   = 2'b10,
        READOUT = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             frame_done_q;
    logic             available_q;
    logic             complete_q;

    logic full;
    logic do_pop;
    logic accept;
    logic wr_en;

    // FIFO write/pop decisions for the current cycle
    always_comb begin
        full   = (count_q == FULL_LVL);
        do_pop = (state_q == READOUT) && bus.read_enable;
        accept = 1'b0;
        case (state_q)
            RECEIVE: accept = bus.sym_valid && !full;
            READOUT: accept = bus.sym_valid && (!full || do_pop);
            default: accept = 1'b0;
        endcase
        wr_en     = accept && enable && !reset;
        count_nxt = count_q + CNT_W'(accept) - CNT_W'(do_pop);
    end

    // Symbol storage; no reset needed, validity is tracked by the pointers
    always_ff @(posedge dclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.sym_data;
        end
    end

    // Control FSM with FIFO pointers and registered host-side outputs
    always_ff @(posedge dclk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            rd_cnt       <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
            available_q  <= 1'b0;
            complete_q   <= 1'b1;
        end else if (!enable) begin
            state_q      <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            rd_cnt       <= '0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            available_q  <= 1'b0;
            complete_q   <= 1'b1;
        end else begin
            rd_valid_q   <= do_pop;
            frame_done_q <= 1'b0;
            count_q      <= count_nxt;
            if (do_pop) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case (state_q)
                IDLE: begin
                    state_q <= RECEIVE;
                end
                RECEIVE: begin
                    if (count_nxt >= FRAME_LVL) begin
                        state_q     <= READY;
                        available_q <= 1'b1;
                        complete_q  <= 1'b0;
                    end
                end
                READY: begin
                    if (bus.read_enable) begin
                        state_q <= READOUT;
                        rd_cnt  <= '0;
                    end
                end
                READOUT: begin
                    if (do_pop) begin
                        if (rd_cnt == LAST_POP) begin
                            rd_cnt       <= '0;
                            frame_done_q <= 1'b1;
                            state_q      <= RECEIVE;
                            available_q  <= 1'b0;
                            complete_q   <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef QAM_DROP_COUNT_EN
    logic        drop_hit;
    logic [15:0] drop_q;

    assign drop_hit = bus.sym_valid && !accept && (state_q != IDLE);

    // Saturating count of refused symbols; only reset clears it
    always_ff @(posedge dclk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (enable && drop_hit && (drop_q != '1)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.state      = state_q;
    assign bus.fill_level = count_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.available  = available_q;
    assign bus.complete   = complete_q;
endmodule
